// File: rtl/ieee1355_tx_char_scheduler.sv
// IEEE1355 per-link transmit character scheduler: picks NULL/FCC/data/EOP per slot,
// applies link parity, tracks transmit credit, and hands characters to the serializer.
module ieee1355_tx_char_scheduler #(
    parameter int G_LINK_PARITY_IS_ODD = 1,
    parameter int G_FCC_CREDIT         = 8,
    parameter int G_MAX_CREDIT         = 56,
    parameter int G_CREDIT_WIDTH       = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_link_run,
    input  logic                      i_fcc_req,
    input  logic                      i_fcc_rx,
    input  logic [8:0]                i_data_in,
    input  logic                      i_data_valid,
    output logic                      o_data_ready,
    output logic                      o_char_valid,
    input  logic                      i_char_ready,
    output logic [9:0]                o_char_bits,
    output logic                      o_char_len,
    output logic [G_CREDIT_WIDTH-1:0] o_credits,
    output logic                      o_credit_error
);

    localparam int CW = G_CREDIT_WIDTH;
    localparam logic [CW:0] LP_FCC = (CW+1)'(G_FCC_CREDIT);
    localparam logic [CW:0] LP_MAX = (CW+1)'(G_MAX_CREDIT);
    localparam logic        LP_ODD = (G_LINK_PARITY_IS_ODD != 0);

    logic          r_char_valid;
    logic [9:0]    r_char_bits;
    logic          r_char_len;
    logic [CW-1:0] r_credits;
    logic          r_credit_error;
    logic [2:0]    r_fcc_pend;
    logic          r_null2_pend;
    logic          r_prev_xor;

    logic          w_slot;
    logic          w_sel_fcc;
    logic          w_sel_data;
    logic          w_sel_esc;
    logic          w_consume;
    logic          w_f;
    logic          w_p;
    logic [7:0]    w_payload;
    logic [CW:0]   w_credit_sum;
    logic          w_credit_ovf;

    // A slot opens only while the link is enabled and out of reset.
    assign w_slot     = ~i_rst & i_enable & (~r_char_valid | i_char_ready);
    assign w_sel_fcc  = ~r_null2_pend & i_link_run & (r_fcc_pend != 3'd0);
    assign w_sel_data = ~r_null2_pend & ~w_sel_fcc & i_link_run
                      & i_data_valid & (r_credits != '0);
    assign w_sel_esc  = ~r_null2_pend & ~w_sel_fcc & ~w_sel_data;
    assign w_consume  = w_slot & w_sel_data;

    always_comb begin
        w_f       = 1'b1;
        w_payload = 8'h00;
        if (w_sel_esc) begin
            w_payload = 8'h03;
        end else if (w_sel_data) begin
            if (i_data_in[8]) begin
                w_payload = i_data_in[0] ? 8'h02 : 8'h01;
            end else begin
                w_f       = 1'b0;
                w_payload = i_data_in[7:0];
            end
        end
    end

    assign w_p = LP_ODD ^ r_prev_xor ^ w_f;

    // Credit arithmetic is one bit wider so overflow past the ceiling is visible.
    assign w_credit_sum = {1'b0, r_credits}
                        + (i_fcc_rx ? LP_FCC : '0)
                        - {{CW{1'b0}}, w_consume};
    assign w_credit_ovf = (w_credit_sum > LP_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            r_char_valid <= 1'b0;
            r_char_bits  <= 10'd0;
            r_char_len   <= 1'b0;
            r_credits    <= '0;
            r_fcc_pend   <= 3'd0;
            r_null2_pend <= 1'b0;
            r_prev_xor   <= 1'b0;
            if (i_rst) begin
                r_credit_error <= 1'b0;
            end
        end else begin
            if (w_slot) begin
                r_char_valid <= 1'b1;
                r_char_bits  <= {w_payload, w_f, w_p};
                r_char_len   <= ~w_f;
                r_prev_xor   <= ^w_payload;
                r_null2_pend <= w_sel_esc;
            end
            if (w_slot && w_sel_fcc) begin
                if (!i_fcc_req) begin
                    r_fcc_pend <= r_fcc_pend - 3'd1;
                end
            end else if (i_fcc_req && r_fcc_pend != 3'd7) begin
                r_fcc_pend <= r_fcc_pend + 3'd1;
            end
            if (w_credit_ovf) begin
                r_credit_error <= 1'b1;
            end else begin
                r_credits <= w_credit_sum[CW-1:0];
            end
        end
    end

    assign o_data_ready   = w_consume;
    assign o_char_valid   = r_char_valid;
    assign o_char_bits    = r_char_bits;
    assign o_char_len     = r_char_len;
    assign o_credits      = r_credits;
    assign o_credit_error = r_credit_error;

endmodule

// File: doc/ieee1355_tx_char_scheduler.md
Name: ieee1355_tx_char_scheduler

Overview:
- Per-link transmit character scheduler for the IEEE1355 link.
- Each character slot, it picks NULL halves, outgoing FCCs, data or EOP characters.
- It computes link parity, tracks transmit credit from received FCCs, and hands whole characters to the bit serializer over a valid/ready handshake.
- Sits between the link state machine and packet TX FIFO on one side and the D/S serializer on the other.

Parameters:
- G_LINK_PARITY_IS_ODD, 1: 1 = odd link parity, 0 = even.
- G_FCC_CREDIT, 8: credits granted per received FCC.
- G_MAX_CREDIT, 56: credit ceiling.
- G_CREDIT_WIDTH, 6: width of the credit counter; must hold G_MAX_CREDIT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  link started; 0 = hold idle
- link_run  in  1  NULL received from far end; data and FCC allowed
- fcc_req  in  1  pulse: local receiver freed buffer space, send one FCC
- fcc_rx  in  1  pulse: FCC received from far end
- data_in  in  9  [8]=EOP marker; [7:0]=data byte, or [0] selects EOP_1(0)/EOP_2(1) when [8]=1
- data_valid  in  1  TX FIFO not empty
- data_ready  out  1  pop strobe for the TX FIFO; combinational
- char_valid  out  1  char_bits holds a character for the serializer
- char_ready  in  1  serializer accepts the character this cycle
- char_bits  out  10  character, LSB transmitted first
- char_len  out  1  0 = 4-bit control character, 1 = 10-bit data character
- credits  out  G_CREDIT_WIDTH  current transmit credit
- credit_error  out  1  sticky: credit overflow

Behaviour:
Reset:
- rst=1 clears all of the following: char_valid, char_bits, char_len, credits, credit_error, fcc_pend, null2_pend, prev_xor.
- Reset applies on the next clk edge and aborts any character in flight.

Disable:
- enable=0 has the same effect as reset, except credit_error is retained.

Character format (bit 0 sent first):
- bit0 = P (parity), bit1 = F (1 = control, 0 = data).
- Control characters: bits[3:2] = code. FCC=00, EOP_1=01, EOP_2=10, ESC=11. Upper bits are 0.
- Data characters: bits[9:2] = byte.
- NULL = ESC immediately followed by FCC.

Parity:
- P = G_LINK_PARITY_IS_ODD ^ prev_xor ^ F.
- prev_xor = XOR of the previous character's code or data bits; it is 0 after reset or enable.
- prev_xor is updated whenever a character is loaded.

Slot and handshake:
- A slot occurs when (enable & !char_valid) or (char_valid & char_ready).
- In a slot, the output register loads the selected character the next clk, and char_valid becomes or stays 1.
- This gives back-to-back characters with zero bubbles.
- char_bits and char_len hold stable while char_valid=1 and char_ready=0.

Selection priority in a slot:
1. null2_pend=1: load FCC (the NULL second half); clear null2_pend. Does not decrement fcc_pend.
2. link_run & fcc_pend>0: load FCC; decrement fcc_pend.
3. link_run & data_valid & credits>0: load data or EOP from data_in; data_ready=1 this cycle; consume 1 credit.
4. Otherwise: load ESC; set null2_pend.

- The first character after enable rises is always ESC (NULL half 1).

FCC requests:
- fcc_pend is a 3-bit counter: +1 per fcc_req, saturating at 7.
- fcc_req in the same cycle as a priority-2 selection leaves the count unchanged.

Credit:
- fcc_rx adds G_FCC_CREDIT; a priority-3 selection subtracts 1. Both in one cycle give a net of G_FCC_CREDIT-1.
- If the result would exceed G_MAX_CREDIT, credits are left unchanged and credit_error is set (sticky until rst).
- credits never underflow: selection 3 requires credits>0.

Other rules:
- link_run falling while enable=1: subsequent slots select only null2 or NULL; credits are retained.
- data_ready is never asserted outside a slot.

Test Plan:
- Odd parity, enable=1, link_run=0, char_ready=1 → char_valid rises 1 clk after enable; char_bits alternates 0x00E (ESC, P=0) and 0x002 (FCC, P=0); char_len=0; data_ready never 1.
- link_run=1, fcc_rx pulse, FIFO holds {0,0x01}, slot after a NULL completes → char_bits=0x005, char_len=1, data_ready pulses once, credits 8→7.
- link_run=1, 3 fcc_req pulses while char_ready=0; then release → exactly 3 FCCs precede any data; no FCC is inserted between ESC and its NULL FCC half.
- 7 fcc_rx pulses → credits=56; 8th pulse → credits stays 56, credit_error=1; fcc_rx plus data send in the same cycle at credits=10 → 17.
- credits=0 with data_valid=1 → only NULLs are sent; data_ready stays 0; one fcc_rx → data is sent in the next slot.
- rst=1 mid-stream with char_ready=0 → next clk: char_valid=0, credits=0, null2_pend=0; after release with enable=1, the first character is 0x00E.
